prio_arbiter: RTL
=================

# prio_arbiter

Parametrised N-input priority arbiter with registered grant and an ack handshake. It generalises the 4-input priority encoder with a valid flag to N requesters. It adds a selectable round-robin mode and holds each grant until the consumer acknowledges it. It sits between request sources (interrupt lines, bus masters) and a single shared resource.

## Interface
Parameters:
- N, 4, number of requesters; legal range 2..32.
- W, $clog2(N), index width; derived, never overridden.

Ports:
- clk  in  1  sole clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request vector; bit i = requester i; level-sensitive.
- mode  in  1  0 = fixed priority, 1 = round-robin.
- ack  in  1  consumer accepts the current grant; only meaningful while grant_vld=1.
- grant_vld  out  1  a grant is being presented.
- grant_idx  out  W  binary index of the granted requester.
- grant_oh  out  N  one-hot of grant_idx; all zero when grant_vld=0.
- any_req  out  1  registered OR of req, sampled every cycle; the successor of the old V flag.

## Operation
- State machine in package enum: IDLE, GRANT.
- IDLE:
  - If req != 0, compute the winner, register grant_idx and grant_oh, set grant_vld=1, and go to GRANT.
  - Otherwise stay in IDLE with grant_vld=0.
- GRANT:
  - Outputs are frozen, even if req drops or changes.
  - ack=1 moves the block to IDLE and clears grant_vld and grant_oh.
  - grant_idx keeps its last value and is don't-care while grant_vld=0.
- Fixed mode: the highest-numbered asserted bit wins (bit N-1 is highest priority).
- Round-robin mode:
  - Search upward from pointer ptr (W bits), wrapping N-1 -> 0; the first asserted bit wins.
  - On ack, ptr <= (grant_idx == N-1) ? 0 : grant_idx+1. The wrap is explicit so non-power-of-two N is correct.
  - ptr updates only on ack, and only when mode=1 at the ack cycle.
- mode is sampled only at arbitration, i.e. in IDLE with req != 0. A change during GRANT takes effect at the next arbitration.
- ack while in IDLE is ignored; no state or pointer change.
- any_req <= |req every cycle, independent of FSM state.
- A single requester holding req continuously in fixed mode is re-granted after every ack. Starvation is permitted in fixed mode only.

## Timing
- Reset values (async, immediate): state=IDLE, grant_vld=0, grant_idx=0, grant_oh=0, any_req=0, ptr=0.
- Request-to-grant latency: req sampled at edge k gives grant_vld=1 after edge k.
- Ack turnaround: ack sampled at edge m gives grant_vld=0 after edge m. Earliest next grant is after edge m+1, so maximum throughput is one grant per 2 cycles.
- Simultaneous ack and new request at edge m: the ack wins and the new request is arbitrated at edge m+1. The request is not dropped, provided it is still asserted.
- Reset asserted mid-GRANT: all outputs clear without waiting for a clock. After rst_n deasserts, the first arbitration occurs at the next edge that sees req != 0.
- any_req is delayed one cycle from req.

## Structure
- Package arb_pkg:
  - arb_state_e {IDLE, GRANT}
  - arb_mode_e {FIXED=0, RR=1}
  - function onehot(idx) returning N bits.
- Sub-module prio_enc:
  - Purely combinational, parametrised by N.
  - Inputs: vector, start index.
  - Outputs: found, index; highest-first for fixed mode, rotating upward from start for RR.
  - The top level instantiates it once and feeds it start=ptr or mode select.
- The top level holds the FSM, output registers and ptr.

## Test plan
- Reset: drive rst_n=0 mid-GRANT with idx=2 -> all outputs 0 immediately; after release with req=0, grant_vld stays 0.
- Fixed priority, N=4, mode=0, req=4'b0110 -> grant_idx=2, grant_oh=0100, one cycle after sampling. Hold ack=0 for 5 cycles and change req to 0001 -> outputs unchanged. Then ack -> grant_vld=0.
- Round-robin, N=4, mode=1, req=4'b1111 held, ack each grant -> grant_idx sequence 0,1,2,3,0, one grant every 2 cycles. ptr wraps 3 -> 0.
- Non-power-of-two, N=5, mode=1, req=5'b10001, ptr starting at 0 -> grants 0, 4, 0. The ptr after granting 4 is 0, not 5.
- Edge cases:
  - ack asserted in IDLE -> no change.
  - mode flipped 0 -> 1 during GRANT -> current grant unchanged, and the next arbitration uses RR.
  - req=0 -> any_req=0 one cycle later.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the N-input priority / round-robin arbiter.
package arb_pkg;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_e;
    typedef enum logic {FIXED = 1'b0, RR = 1'b1} arb_mode_e;

    localparam int MAX_N = 32;

    // Full-width one-hot; callers slice down to their own N.
    function automatic logic [MAX_N-1:0] onehot(input logic [4:0] idx);
        logic [MAX_N-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between request sources (master) and the arbiter (slave).
interface prio_arbiter_if #(
    parameter int N = 4
);
    localparam int W = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0] req;
    logic         mode;
    logic         ack;
    logic         grant_vld;
    logic [W-1:0] grant_idx;
    logic [N-1:0] grant_oh;
    logic         any_req;

    modport master (
        output req, mode, ack,
        input  grant_vld, grant_idx, grant_oh, any_req
    );

    modport slave (
        input  req, mode, ack,
        output grant_vld, grant_idx, grant_oh, any_req
    );

endinterface

// File: rtl/prio_arbiter_prio_enc.sv
// Combinational winner search: highest bit first in fixed mode, upward
// from start with wrap-around in round-robin mode.
module prio_enc #(
    parameter int N = 4,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    input  logic         rr,
    output logic         found,
    output logic [W-1:0] idx
);

    always_comb begin
        int p;
        p     = 0;
        found = |vec;
        idx   = '0;
        if (rr) begin
            // Walk distances from far to near so the closest hit overwrites last.
            for (int k = N - 1; k >= 0; k--) begin
                p = int'(start) + k;
                if (p >= N) p = p - N;
                if (vec[p]) idx = W'(p);
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (vec[i]) idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_arbiter.sv
// N-input arbiter with registered grant held until ack; fixed or round-robin
// selection chosen per arbitration by mode.
module prio_arbiter
    import arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    prio_arbiter_if.slave  bus
);

    localparam int W = (N > 1) ? $clog2(N) : 1;

    arb_state_e       state_reg, state_next;
    logic             grant_vld_reg, grant_vld_next;
    logic [W-1:0]     grant_idx_reg, grant_idx_next;
    logic [N-1:0]     grant_oh_reg, grant_oh_next;
    logic [W-1:0]     ptr_reg, ptr_next;
    logic             any_req_reg;

    logic             enc_found;
    logic [W-1:0]     enc_idx;
    logic [MAX_N-1:0] enc_oh;

    prio_enc #(.N(N)) u_enc (
        .vec   (bus.req),
        .start (ptr_reg),
        .rr    (bus.mode),
        .found (enc_found),
        .idx   (enc_idx)
    );

    assign enc_oh = onehot(5'(enc_idx));

    always_comb begin
        state_next     = state_reg;
        grant_vld_next = grant_vld_reg;
        grant_idx_next = grant_idx_reg;
        grant_oh_next  = grant_oh_reg;
        ptr_next       = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (enc_found) begin
                    state_next     = GRANT;
                    grant_vld_next = 1'b1;
                    grant_idx_next = enc_idx;
                    grant_oh_next  = enc_oh[N-1:0];
                end
            end
            GRANT: begin
                // Outputs stay frozen until the consumer takes the grant.
                if (bus.ack) begin
                    state_next     = IDLE;
                    grant_vld_next = 1'b0;
                    grant_oh_next  = '0;
                    if (arb_mode_e'(bus.mode) == RR) begin
                        ptr_next = (grant_idx_reg == W'(N - 1)) ? '0 : grant_idx_reg + W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            grant_vld_reg <= 1'b0;
            grant_idx_reg <= '0;
            grant_oh_reg  <= '0;
            ptr_reg       <= '0;
            any_req_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            grant_vld_reg <= grant_vld_next;
            grant_idx_reg <= grant_idx_next;
            grant_oh_reg  <= grant_oh_next;
            ptr_reg       <= ptr_next;
            any_req_reg   <= |bus.req;
        end
    end

    assign bus.grant_vld = grant_vld_reg;
    assign bus.grant_idx = grant_idx_reg;
    assign bus.grant_oh  = grant_oh_reg;
    assign bus.any_req   = any_req_reg;

endmodule
